run_length_monitor: RTL and testbench

RUN_LENGTH_MONITOR -- requirements
Module: run_length_monitor

---
 rtl/run_length_monitor.sv | 96 +++++++++
 tb/tb_run_length_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/run_length_monitor.sv
// Tracks the length of the current run of repeated samples, flags saturation and a
// threshold crossing, and records the longest run seen since reset or clear.
module run_length_monitor #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] val,
    input  logic              clear,
    input  logic [CNT_W-1:0]  threshold,
    output logic [CNT_W-1:0]  run_cnt,
    output logic              run_sat,
    output logic              run_hit,
    output logic [CNT_W-1:0]  max_run,
    output logic [DATA_W-1:0] max_val
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              run_sat_q, run_sat_d;
    logic              run_hit_q, run_hit_d;
    logic [CNT_W-1:0]  max_run_q, max_run_d;
    logic [DATA_W-1:0] max_val_q, max_val_d;
    logic [DATA_W-1:0] prev_val_q, prev_val_d;
    logic              have_prev_q, have_prev_d;

    logic              accept;
    logic              same;
    logic [CNT_W-1:0]  cnt_upd;

    assign accept  = in_valid && !clear;
    assign same    = have_prev_q && (val == prev_val_q);
    assign cnt_upd = !same                  ? '0 :
                     (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_W'(1);

    always_comb begin
        run_cnt_d   = run_cnt_q;
        run_sat_d   = run_sat_q;
        run_hit_d   = 1'b0;
        max_run_d   = max_run_q;
        max_val_d   = max_val_q;
        prev_val_d  = prev_val_q;
        have_prev_d = have_prev_q;
        if (clear) begin
            run_cnt_d   = '0;
            run_sat_d   = 1'b0;
            max_run_d   = '0;
            max_val_d   = '0;
            prev_val_d  = '0;
            have_prev_d = 1'b0;
        end else if (accept) begin
            run_cnt_d   = cnt_upd;
            // CNT_W >= 2 means a fresh run (0) can never look saturated.
            run_sat_d   = (cnt_upd == CNT_MAX);
            // Requiring a change of count stops a saturated run from re-pulsing.
            run_hit_d   = (threshold != '0) && (cnt_upd == threshold) &&
                          (cnt_upd != run_cnt_q);
            prev_val_d  = val;
            have_prev_d = 1'b1;
            if (cnt_upd > max_run_q) begin
                max_run_d = cnt_upd;
                max_val_d = val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q   <= '0;
            run_sat_q   <= 1'b0;
            run_hit_q   <= 1'b0;
            max_run_q   <= '0;
            max_val_q   <= '0;
            prev_val_q  <= '0;
            have_prev_q <= 1'b0;
        end else begin
            run_cnt_q   <= run_cnt_d;
            run_sat_q   <= run_sat_d;
            run_hit_q   <= run_hit_d;
            max_run_q   <= max_run_d;
            max_val_q   <= max_val_d;
            prev_val_q  <= prev_val_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign run_cnt = run_cnt_q;
    assign run_sat = run_sat_q;
    assign run_hit = run_hit_q;
    assign max_run = max_run_q;
    assign max_val = max_val_q;

endmodule

// File: tb/tb_run_length_monitor.sv
// Directed bench for run_length_monitor: a default-width instance plus a 3-bit
// counter instance for saturation, sharing the sample stream.
module tb_run_length_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  val;
    logic        clear;
    logic [31:0] threshold;
    logic [31:0] run_cnt, max_run;
    logic        run_sat, run_hit;
    logic [7:0]  max_val;

    logic [2:0]  threshold2;
    logic [2:0]  run_cnt2, max_run2;
    logic        run_sat2, run_hit2;
    logic [7:0]  max_val2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_length_monitor #(.DATA_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .val(val), .clear(clear),
        .threshold(threshold), .run_cnt(run_cnt), .run_sat(run_sat),
        .run_hit(run_hit), .max_run(max_run), .max_val(max_val)
    );

    run_length_monitor #(.DATA_W(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .val(val), .clear(clear),
        .threshold(threshold2), .run_cnt(run_cnt2), .run_sat(run_sat2),
        .run_hit(run_hit2), .max_run(max_run2), .max_val(max_val2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [7:0] v);
        in_valid = 1'b1;
        val      = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cnt"}, run_cnt, 0);
        chk({tag, ".sat"}, 32'(run_sat), 0);
        chk({tag, ".hit"}, 32'(run_hit), 0);
        chk({tag, ".max"}, max_run, 0);
        chk({tag, ".mval"}, 32'(max_val), 0);
    endtask

    initial begin
        logic [7:0] seq [6];
        int         exp_cnt [6];
        seq     = '{8'd7, 8'd7, 8'd7, 8'd9, 8'd9, 8'd7};
        exp_cnt = '{0, 1, 2, 0, 1, 0};

        rst_n = 1'b0; in_valid = 1'b0; val = '0; clear = 1'b0;
        threshold = '0; threshold2 = 3'd7;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Run of zeros: the first zero must start a fresh run.
        for (int i = 0; i < 3; i++) begin
            sample(8'd0);
            chk($sformatf("zeros.cnt%0d", i), run_cnt, 32'(i));
            chk($sformatf("zeros.hit%0d", i), 32'(run_hit), 0);
        end
        chk("zeros.max", max_run, 2);
        chk("zeros.mval", 32'(max_val), 0);

        do_clear();
        chk_all_zero("clr1");

        // Threshold crossing pulses once.
        threshold = 32'd3;
        for (int i = 0; i < 5; i++) begin
            sample(8'd5);
            chk($sformatf("thr.cnt%0d", i), run_cnt, 32'(i));
            chk($sformatf("thr.hit%0d", i), 32'(run_hit), (i == 3) ? 32'd1 : 32'd0);
        end
        idle();
        chk("thr.idle_cnt", run_cnt, 4);
        chk("thr.idle_hit", 32'(run_hit), 0);
        chk("thr.max", max_run, 4);
        chk("thr.mval", 32'(max_val), 5);

        do_clear();
        threshold = '0;
        for (int i = 0; i < 6; i++) begin
            sample(seq[i]);
            chk($sformatf("gap.cnt%0d", i), run_cnt, 32'(exp_cnt[i]));
            idle();
            chk($sformatf("gap.hold%0d", i), run_cnt, 32'(exp_cnt[i]));
        end
        chk("gap.max", max_run, 2);
        chk("gap.mval", 32'(max_val), 7);

        // Clear wins over a simultaneous valid sample.
        do_clear();
        for (int i = 0; i < 4; i++) sample(8'd1);
        chk("clr.pre", run_cnt, 3);
        in_valid = 1'b1; val = 8'd1;
        do_clear();
        in_valid = 1'b0;
        chk_all_zero("clr2");
        sample(8'd1);
        chk("clr.after", run_cnt, 0);
        do_clear();
        sample(8'd0);
        chk("clr.zero_first", run_cnt, 0);

        // Saturation on the 3-bit instance; its threshold of 7 must pulse only once.
        do_clear();
        for (int i = 0; i < 10; i++) begin
            sample(8'd4);
            chk($sformatf("sat.cnt%0d", i), 32'(run_cnt2), (i < 7) ? 32'(i) : 32'd7);
            chk($sformatf("sat.sat%0d", i), 32'(run_sat2), (i >= 7) ? 32'd1 : 32'd0);
            chk($sformatf("sat.hit%0d", i), 32'(run_hit2), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("sat.max", 32'(max_run2), 7);
        sample(8'd6);
        chk("sat.new_cnt", 32'(run_cnt2), 0);
        chk("sat.new_sat", 32'(run_sat2), 0);
        chk("sat.keep_max", 32'(max_run2), 7);
        chk("sat.keep_mval", 32'(max_val2), 4);

        // Asynchronous reset mid-run, held across edges.
        do_clear();
        for (int i = 0; i < 3; i++) sample(8'd2);
        chk("arst.pre", run_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst.async");
        in_valid = 1'b1; val = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("arst.held");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sample(8'd2);
        chk("arst.first", run_cnt, 0);
        sample(8'd2);
        chk("arst.second", run_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
